// File: rtl/gups_engine_if.sv
// Memory request port between the GUPS engine and the memory controller.
// A single request is outstanding at a time; ready marks acceptance at the clock edge.
interface gups_engine_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] dataOut;
  logic [DATA_W-1:0] dataIn;
  logic              request;
  logic              write;
  logic              ready;

  modport master (output address, dataOut, request, write, input dataIn, ready);
  modport slave  (input address, dataOut, request, write, output dataIn, ready);
endinterface

// File: rtl/gups_engine.sv
// Random-access update engine: a 64-bit Galois LFSR picks table indices and each one
// gets a read-modify-write on the memory port, for a programmed number of updates.
module gups_engine #(
  parameter int          ADDR_W = 64,
  parameter int          DATA_W = 64,
  parameter int          CNT_W  = 32,
  parameter logic [63:0] POLY   = 64'h7,
  parameter int          ALIGN  = 3,
  parameter bit          MODE   = 1'b0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [63:0]      seed_i,
  input  logic [63:0]      range_i,
  input  logic [CNT_W-1:0] numUpdates_i,
  gups_engine_if.master    mem,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] cycles_o
);

  // Wide enough that the index shift never loses bits before the final truncation.
  localparam int SHIFT_W = (ADDR_W > 64 + ALIGN) ? ADDR_W : 64 + ALIGN;

  typedef enum logic [2:0] {IDLE, GEN, READ, WRITE, DONE} state_e;

  state_e             state_q, state_d;
  logic [63:0]        lfsr_q, lfsr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wrData_q, wrData_d;
  logic               req_q, req_d;
  logic               wr_q, wr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;

  logic [63:0]        lfsrNext;
  logic [SHIFT_W-1:0] indexWide;
  logic [ADDR_W-1:0]  addrNext;
  logic [DATA_W-1:0]  updateVal;
  logic [CNT_W-1:0]   countInc;
  logic               lastUpdate;

  always_comb begin
    lfsrNext   = {lfsr_q[62:0], 1'b0} ^ (lfsr_q[63] ? POLY : 64'd0);
    indexWide  = SHIFT_W'(lfsrNext & range_i);
    addrNext   = ADDR_W'(indexWide << ALIGN);
    updateVal  = MODE ? (mem.dataIn + DATA_W'(1)) : (mem.dataIn ^ DATA_W'(lfsr_q));
    countInc   = count_q + CNT_W'(1);
    lastUpdate = (countInc == numUpdates_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      lfsr_q   <= 64'd1;
      addr_q   <= '0;
      wrData_q <= '0;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      count_q  <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      addr_q   <= addr_d;
      wrData_q <= wrData_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      count_q  <= count_d;
      cycles_q <= cycles_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (numUpdates_i == '0) ? DONE : GEN;
      GEN:     state_d = READ;
      READ:    if (mem.ready) state_d = WRITE;
      WRITE:   if (mem.ready) state_d = lastUpdate ? DONE : GEN;
      DONE:    if (!start_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; with ready low in READ/WRITE everything simply holds.
  always_comb begin
    lfsr_d   = lfsr_q;
    addr_d   = addr_q;
    wrData_d = wrData_q;
    req_d    = req_q;
    wr_d     = wr_q;
    count_d  = count_q;
    cycles_d = cycles_q;
    if (busy_o && !(&cycles_q)) cycles_d = cycles_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          lfsr_d   = (seed_i == 64'd0) ? 64'd1 : seed_i;
          count_d  = '0;
          cycles_d = '0;
        end
      end
      GEN: begin
        lfsr_d = lfsrNext;
        addr_d = addrNext;
        req_d  = 1'b1;
        wr_d   = 1'b0;
      end
      READ: begin
        if (mem.ready) begin
          wrData_d = updateVal;
          wr_d     = 1'b1;
        end
      end
      WRITE: begin
        if (mem.ready) begin
          req_d   = 1'b0;
          wr_d    = 1'b0;
          count_d = countInc;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy_o = (state_q == GEN) || (state_q == READ) || (state_q == WRITE);
    done_o = (state_q == DONE);
  end

  assign mem.address = addr_q;
  assign mem.dataOut = wrData_q;
  assign mem.request = req_q;
  assign mem.write   = wr_q;
  assign count_o     = count_q;
  assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_gups_engine.sv
// Scoreboard bench for gups_engine: a reference LFSR predicts every bus request,
// and a negedge monitor compares each request against the front of the queue.
module tb_gups_engine;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] seed = '0;
  logic [63:0] range = '0;
  logic [31:0] numUpdates = '0;
  logic        busy, done;
  logic [31:0] count, cycles;

  logic        start1 = 1'b0;
  logic [63:0] seed1 = 64'd1;
  logic [63:0] range1 = 64'hFF;
  logic [31:0] num1 = 32'd1;
  logic        busy1, done1;
  logic [31:0] count1, cycles1;

  int   testsRun = 0;
  int   failCount = 0;
  txn_t sb[$];

  gups_engine_if mem0 ();
  gups_engine_if mem1 ();

  gups_engine dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .seed_i(seed), .range_i(range),
    .numUpdates_i(numUpdates), .mem(mem0), .busy_o(busy), .done_o(done),
    .count_o(count), .cycles_o(cycles)
  );

  gups_engine #(.MODE(1'b1)) dutMode1 (
    .clk_i(clk), .reset_i(reset), .start_i(start1), .seed_i(seed1), .range_i(range1),
    .numUpdates_i(num1), .mem(mem1), .busy_o(busy1), .done_o(done1),
    .count_o(count1), .cycles_o(cycles1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] lfsrStep(input logic [63:0] x);
    return {x[62:0], 1'b0} ^ (x[63] ? 64'h7 : 64'h0);
  endfunction

  // Every request seen on the bus must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (!reset && mem0.request) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedReq", 64'd1, 64'd0);
      end else begin
        checkOutput("reqWrite", 64'(mem0.write), 64'(sb[0].we));
        checkOutput("reqAddr", mem0.address, sb[0].addr);
        if (sb[0].we) checkOutput("wrData", mem0.dataOut, sb[0].data);
        if (mem0.ready) void'(sb.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [63:0] seedV, input logic [63:0] rangeV,
                               input int numV, input logic [63:0] dataV, input int stall,
                               input bit holdStart, input bit abortWrite);
    logic [63:0] s;
    txn_t        t;
    int          waitCnt;
    int          cyc;
    bit          prevReq;
    bit          prevWr;
    s = (seedV == 64'd0) ? 64'd1 : seedV;
    for (int i = 0; i < numV; i++) begin
      s = lfsrStep(s);
      t.we = 1'b0; t.addr = (s & rangeV) << 3; t.data = '0;
      sb.push_back(t);
      t.we = 1'b1; t.data = dataV ^ s;
      sb.push_back(t);
    end
    @(posedge clk); #2;
    start = 1'b0;
    mem0.ready = 1'b0;
    @(posedge clk); #2;
    seed = seedV; range = rangeV; numUpdates = 32'(numV); mem0.dataIn = dataV;
    start = 1'b1;
    waitCnt = 0; cyc = 0; prevReq = 1'b0; prevWr = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!holdStart) start = 1'b0;
      if (cyc == 0 && numV != 0) begin
        checkOutput("busyAfterStart", 64'(busy), 64'd1);
        checkOutput("countCleared", 64'(count), 64'd0);
        checkOutput("cyclesCleared", 64'(cycles), 64'd0);
      end
      cyc++;
      if (done) break;
      if (cyc > 400) begin
        checkOutput("runTimeout", 64'd1, 64'd0);
        break;
      end
      if (mem0.request) begin
        if (!prevReq || (mem0.write != prevWr)) waitCnt = 0;
        if (abortWrite && mem0.write && waitCnt == 3) begin
          mem0.ready = 1'b0;
          reset = 1'b1;
          return;
        end
        mem0.ready = (waitCnt >= stall);
        waitCnt++;
      end else begin
        mem0.ready = 1'b0;
      end
      prevReq = mem0.request;
      prevWr  = mem0.write;
    end
    mem0.ready = 1'b0;
  endtask

  task automatic checkRun(input int numV, input int cyclesExp);
    checkOutput("doneFlag", 64'(done), 64'd1);
    checkOutput("busyAtDone", 64'(busy), 64'd0);
    checkOutput("reqAtDone", 64'(mem0.request), 64'd0);
    checkOutput("count", 64'(count), 64'(numV));
    checkOutput("cycles", 64'(cycles), 64'(cyclesExp));
    checkOutput("sbEmpty", 64'(sb.size()), 64'd0);
  endtask

  task automatic runModeOne(input logic [63:0] dataV, input logic [63:0] expData);
    int cyc;
    @(posedge clk); #2;
    mem1.dataIn = dataV;
    start1 = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #2;
      start1 = 1'b0;
      cyc++;
    end while (!done1 && cyc < 50);
    checkOutput("m1Done", 64'(done1), 64'd1);
    checkOutput("m1Data", mem1.dataOut, expData);
    checkOutput("m1Addr", mem1.address, 64'h10);
    checkOutput("m1Cycles", 64'(cycles1), 64'd3);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] rs, rr, rd;
    int          rn, rst;
    mem0.ready = 1'b0; mem0.dataIn = '0;
    mem1.ready = 1'b1; mem1.dataIn = '0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rstRequest", 64'(mem0.request), 64'd0);
    checkOutput("rstWrite", 64'(mem0.write), 64'd0);
    checkOutput("rstAddress", mem0.address, 64'd0);
    checkOutput("rstDataOut", mem0.dataOut, 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstDone", 64'(done), 64'd0);
    checkOutput("rstCount", 64'(count), 64'd0);
    checkOutput("rstCycles", 64'(cycles), 64'd0);
    reset = 1'b0;

    applyStimulus(64'd1, 64'hFF, 2, 64'hF0, 0, 1'b0, 1'b0);
    checkRun(2, 6);
    applyStimulus(64'h8000_0000_0000_0000, 64'hF, 1, 64'hF0, 0, 1'b0, 1'b0);
    checkRun(1, 3);
    applyStimulus(64'd0, 64'hFF, 2, 64'hF0, 0, 1'b0, 1'b0);
    checkRun(2, 6);
    applyStimulus(64'h1234_5678_9ABC_DEF0, 64'hFFFF, 1, 64'hA5A5, 5, 1'b0, 1'b0);
    checkRun(1, 13);

    applyStimulus(64'd7, 64'hFF, 0, 64'h0, 0, 1'b0, 1'b0);
    checkRun(0, 0);
    applyStimulus(64'd3, 64'hFF, 3, 64'h55, 0, 1'b1, 1'b0);
    checkRun(3, 9);
    repeat (4) @(posedge clk);
    #2;
    checkOutput("holdDone", 64'(done), 64'd1);
    checkOutput("holdBusy", 64'(busy), 64'd0);
    checkOutput("holdCount", 64'(count), 64'd3);
    applyStimulus(64'd9, 64'hFF, 2, 64'h77, 1, 1'b0, 1'b0);
    checkRun(2, 10);

    applyStimulus(64'd5, 64'hFFFF, 2, 64'h3C, 10, 1'b0, 1'b1);
    @(posedge clk); #2;
    sb.delete();
    reset = 1'b0;
    checkOutput("abortRequest", 64'(mem0.request), 64'd0);
    checkOutput("abortBusy", 64'(busy), 64'd0);
    checkOutput("abortCount", 64'(count), 64'd0);
    checkOutput("abortDone", 64'(done), 64'd0);
    applyStimulus(64'd5, 64'hFFFF, 3, 64'h3C, 0, 1'b0, 1'b0);
    checkRun(3, 9);

    for (int r = 0; r < 4; r++) begin
      rs  = {$urandom, $urandom};
      rr  = {$urandom, $urandom};
      rd  = {$urandom, $urandom};
      rn  = $urandom_range(1, 4);
      rst = $urandom_range(0, 2);
      applyStimulus(rs, rr, rn, rd, rst, 1'b0, 1'b0);
      checkRun(rn, rn * (3 + 2 * rst));
    end

    runModeOne(64'd5, 64'd6);
    runModeOne(64'hFFFF_FFFF_FFFF_FFFF, 64'd0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/gups_engine.md
# gups_engine

Parametrised random-access update engine: the next generation of the team's single-channel GUPS traffic generator. It produces a pseudo-random address stream from a 64-bit Galois LFSR and masks it to a configurable table range. For each address it performs one read-modify-write on the memory port, repeating for a programmed number of updates. It sits between the control registers (SEED, RANGE, NUM_UPDATES, START) and the memory controller request port, and reports completion and elapsed cycles for the GUPS figure.

## Interface
- ADDR_W, 64: ADDRESS width; the low ADDR_W bits of the shifted, masked LFSR value are used.
- DATA_W, 64: data path width.
- CNT_W, 32: update counter and cycle counter width.
- POLY, 64'h7: Galois feedback taps (x^64 + x^2 + x + 1).
- ALIGN, 3: left shift from table index to byte address (3 = 64-bit words).
- MODE, 0: update operation; 0 = DATA_IN ^ LFSR value (low DATA_W bits), 1 = DATA_IN + 1 (mod 2^DATA_W).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  level; sampled in IDLE and DONE.
- SEED  in  64  LFSR seed, loaded at start; zero is replaced by 1.
- RANGE  in  64  index mask, applied as LFSR & RANGE.
- NUM_UPDATES  in  CNT_W  updates per run.
- ADDRESS  out  ADDR_W  request address.
- DATA_OUT  out  DATA_W  write data.
- DATA_IN  in  DATA_W  read data, valid in the cycle READY=1 for a read.
- REQUEST  out  1  request valid.
- WRITE  out  1  1 = write, 0 = read; qualifies REQUEST.
- READY  in  1  request accepted at this edge.
- BUSY  out  1  high in GEN, READ and WRITE.
- DONE  out  1  high in the DONE state.
- COUNT  out  CNT_W  completed updates.
- CYCLES  out  CNT_W  cycles spent busy, saturating at all-ones.

## Operation
- States: IDLE, GEN, READ, WRITE, DONE.
- IDLE, START=1:
  - Load the LFSR with SEED (1 if SEED=0) and clear COUNT and CYCLES.
  - Go to DONE if NUM_UPDATES=0; otherwise go to GEN.
- GEN (one cycle):
  - Compute next = {lfsr[62:0],1'b0} ^ (lfsr[63] ? POLY : 0) and store it in the LFSR.
  - ADDRESS <= ((next & RANGE) << ALIGN)[ADDR_W-1:0].
  - REQUEST <= 1, WRITE <= 0; go to READ.
- READ, READY=1:
  - DATA_OUT <= MODE ? DATA_IN+1 : DATA_IN ^ lfsr[DATA_W-1:0] (zero-extended when DATA_W > 64).
  - WRITE <= 1 with REQUEST held at 1 and ADDRESS unchanged; go to WRITE.
- WRITE, READY=1:
  - REQUEST <= 0, WRITE <= 0, COUNT <= COUNT+1.
  - Go to DONE if COUNT+1 == NUM_UPDATES; otherwise go to GEN.
- DONE: DONE=1. START=0 returns to IDLE. While START stays high, the engine does not restart.
- READY=0 in READ or WRITE: hold every output stable; there is no timeout.
- READY outside READ/WRITE is ignored. Only one request is outstanding at a time.
- SEED, RANGE and NUM_UPDATES are sampled live; software holds them stable while BUSY=1.
- CYCLES increments in every GEN, READ and WRITE cycle.

## Timing
- Reset values: REQUEST=0, WRITE=0, ADDRESS=0, DATA_OUT=0, BUSY=0, DONE=0, COUNT=0, CYCLES=0, LFSR=1, state IDLE.
- RESET mid-run drops REQUEST at the next edge and aborts the run with no completion write. RESET has priority over every event.
- START is accepted at edge e0; GEN occupies cycle e0..e1 and REQUEST rises at e1.
- If READY=1 is already present in the first READ cycle, the read is accepted at that edge.
- With READY tied high, each update takes 3 cycles, and after N updates CYCLES = 3N.
- DONE rises on the edge that accepts the final write, and REQUEST falls on that same edge.
- COUNT wraps modulo 2^CNT_W. NUM_UPDATES = 2^CNT_W-1 is the maximum run length.

## Test plan
- SEED=1, RANGE=0xFF, ALIGN=3, NUM_UPDATES=2, READY=1 -> reads at ADDRESS 0x10 and 0x20, each followed by a write to the same address; DONE=1, COUNT=2, CYCLES=6.
- MODE=0, SEED=1, DATA_IN=0xF0 -> DATA_OUT=0xF2. MODE=1, DATA_IN=0xFFFF_FFFF_FFFF_FFFF -> DATA_OUT=0.
- SEED=0x8000_0000_0000_0000, RANGE=0xF -> first LFSR value 7 and ADDRESS=0x38. SEED=0 behaves identically to SEED=1.
- READY held low for 5 cycles in both READ and WRITE -> REQUEST, WRITE, ADDRESS and DATA_OUT stay stable; CYCLES=13 after one update.
- NUM_UPDATES=0 with START=1 -> DONE with no REQUEST ever asserted. START held high in DONE -> no restart; dropping then raising START starts a new run with COUNT cleared.
- RESET asserted during WRITE with READY=0 -> next cycle REQUEST=0, BUSY=0, COUNT=0, state IDLE; a subsequent START runs normally from SEED.
